// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 7/8 data bits LSB-first, none/odd/even parity, 1/2 stop bits, 4 baud rates.
// Latency: rx_active rises 3 clocks after the line falls; rx_done fires 1 clock after the last stop-bit mid-sample.
// No backpressure: rx_done is a single-cycle strobe and data_out/error flags hold until the next completed frame.
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       frame_error
);

  // Divisors rounded to nearest: (CLK + den/2) / den with den = baud * OVERSAMPLE.
  localparam int DIV_2400  = (CLK_HZ + (2400  * OVERSAMPLE) / 2) / (2400  * OVERSAMPLE);
  localparam int DIV_4800  = (CLK_HZ + (4800  * OVERSAMPLE) / 2) / (4800  * OVERSAMPLE);
  localparam int DIV_9600  = (CLK_HZ + (9600  * OVERSAMPLE) / 2) / (9600  * OVERSAMPLE);
  localparam int DIV_19200 = (CLK_HZ + (19200 * OVERSAMPLE) / 2) / (19200 * OVERSAMPLE);

  // Tick index of the mid-bit point in the start bit, and the last tick of a full bit window.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        line_prev;
  logic        start_det;

  logic [1:0]  cfg_baud;
  logic [1:0]  cfg_par;
  logic        cfg_stop;
  logic        cfg_len;

  logic [15:0] tick_cnt;
  logic [15:0] tick_lim;
  logic        tick;

  logic [3:0]  samp_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  last_bit;
  logic [7:0]  shreg;
  logic        par_en;
  logic        par_exp;
  logic        par_err_int;
  logic        frm_err_int;

  // Two-flop synchronizer plus edge register; all idle-high so reset never looks like a start edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= data_in;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  // A start edge is accepted in IDLE and also in the single DONE cycle, so an early next start is not lost.
  assign start_det = line_prev && !sync2 && ((state == S_IDLE) || (state == S_DONE));

  // Divisor follows the latched baud select so a mid-frame change cannot disturb bit timing.
  always_comb begin
    tick_lim = 16'(DIV_9600 - 1);
    case (cfg_baud)
      2'b00:   tick_lim = 16'(DIV_2400 - 1);
      2'b01:   tick_lim = 16'(DIV_4800 - 1);
      2'b10:   tick_lim = 16'(DIV_9600 - 1);
      default: tick_lim = 16'(DIV_19200 - 1);
    endcase
  end

  assign tick = (tick_cnt == tick_lim);

  // Free-running oversample tick; restarting at the start edge phase-aligns sample points to the frame.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (start_det || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign last_bit = cfg_len ? 3'd7 : 3'd6;
  assign par_en   = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  // Even parity bit is the XOR of the data; odd is its inverse. Bit 7 is never written in 7-bit mode.
  assign par_exp  = (^shreg) ^ (cfg_par == 2'b01);

  // Frame FSM: outputs are loaded on the edge that enters DONE so rx_done, rx_active falling and new data coincide.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cfg_baud     <= 2'b00;
      cfg_par      <= 2'b00;
      cfg_stop     <= 1'b0;
      cfg_len      <= 1'b0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_err_int  <= 1'b0;
      frm_err_int  <= 1'b0;
      data_out     <= 8'h00;
      rx_done      <= 1'b0;
      rx_active    <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_det) begin
            state       <= S_START;
            rx_active   <= 1'b1;
            cfg_baud    <= baud_rate;
            cfg_par     <= parity_type;
            cfg_stop    <= stop_bits;
            cfg_len     <= data_length;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_err_int <= 1'b0;
            frm_err_int <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_START: begin
          if (tick) begin
            if (samp_cnt == MID_TICK) begin
              if (!sync2) begin
                samp_cnt <= '0;
                state    <= S_DATA;
              end else begin
                // Line back high at mid-start: a glitch, drop it without touching the outputs.
                state     <= S_IDLE;
                rx_active <= 1'b0;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == LAST_TICK) begin
              shreg[bit_cnt] <= sync2;
              if (bit_cnt == last_bit) begin
                bit_cnt <= '0;
                state   <= par_en ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == LAST_TICK) begin
              par_err_int <= (sync2 != par_exp);
              state       <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == LAST_TICK) begin
              if (bit_cnt[0] == cfg_stop) begin
                // Last stop sample: fold it straight into the published frame error.
                state        <= S_DONE;
                data_out     <= shreg;
                parity_error <= par_err_int;
                frame_error  <= frm_err_int | !sync2;
                rx_done      <= 1'b1;
                rx_active    <= 1'b0;
              end else begin
                frm_err_int <= frm_err_int | !sync2;
                bit_cnt     <= bit_cnt + 3'd1;
              end
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 2 MHz clock parameter to keep frames short.
// Bit periods at 2 MHz: DIV = 52/26/13/7 clocks per tick, so 832/416/208/112 clocks per bit.
// Inputs are driven on falling edges and outputs sampled on falling edges.
module tb_uart_rx;

  localparam int BIT_2400  = 832;
  localparam int BIT_4800  = 416;
  localparam int BIT_9600  = 208;
  localparam int BIT_19200 = 112;
  localparam int TICK_9600 = 13;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [1:0] baud_rate   = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits   = 1'b0;
  logic       data_length = 1'b1;
  logic       data_in     = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       frame_error;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int run      = 0;
  int max_run  = 0;

  uart_rx #(.CLK_HZ(2_000_000), .OVERSAMPLE(16)) dut (
    .clock        (clock),
    .rst          (rst),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_in      (data_in),
    .data_out     (data_out),
    .rx_done      (rx_done),
    .rx_active    (rx_active),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  // Count rx_done pulses and track the widest pulse seen.
  always @(negedge clock) begin
    if (rx_done) begin
      if (run == 0) done_cnt = done_cnt + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting now (caller sits on a falling edge); par: 0 none, 1 odd, 2 even.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par, input bit flip,
                            input int nstop, input bit stop_low, input int bclk);
    logic p;
    data_in = 1'b0;
    repeat (bclk) @(negedge clock);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      data_in = d[i];
      p = p ^ d[i];
      repeat (bclk) @(negedge clock);
    end
    if (par != 0) begin
      if (par == 1) p = ~p;
      if (flip) p = ~p;
      data_in = p;
      repeat (bclk) @(negedge clock);
    end
    for (int s = 0; s < nstop; s++) begin
      data_in = (s == 0) ? ~stop_low : 1'b1;
      repeat (bclk) @(negedge clock);
    end
    data_in = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clock);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst_rx_active", rx_active, 1'b0);
    chk("rst_parity_error", parity_error, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clock);

    // Basic 8N1 at 9600 with detection latency
    baud_rate = 2'b10; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    fork
      send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b0, BIT_9600);
      begin
        repeat (2) @(negedge clock);
        chk("latency_2clk", rx_active, 1'b0);
        @(negedge clock);
        chk("latency_3clk", rx_active, 1'b1);
      end
    join
    repeat (10) @(negedge clock);
    chk("8n1_done_cnt", done_cnt, 1);
    chk("8n1_data", data_out, 8'hA5);
    chk("8n1_parity_error", parity_error, 1'b0);
    chk("8n1_frame_error", frame_error, 1'b0);
    chk("8n1_rx_active", rx_active, 1'b0);

    // 7E2 at 19200, correct then flipped parity
    baud_rate = 2'b11; parity_type = 2'b10; stop_bits = 1'b1; data_length = 1'b0;
    send_frame(8'h41, 7, 2, 1'b0, 2, 1'b0, BIT_19200);
    repeat (10) @(negedge clock);
    chk("7e2_done_cnt", done_cnt, 2);
    chk("7e2_data", data_out, 8'h41);
    chk("7e2_parity_error", parity_error, 1'b0);
    chk("7e2_frame_error", frame_error, 1'b0);
    send_frame(8'h41, 7, 2, 1'b1, 2, 1'b0, BIT_19200);
    repeat (10) @(negedge clock);
    chk("7e2_bad_done_cnt", done_cnt, 3);
    chk("7e2_bad_data", data_out, 8'h41);
    chk("7e2_bad_parity_error", parity_error, 1'b1);

    // 8O1 at 2400, 0x00 with stop bit low
    baud_rate = 2'b00; parity_type = 2'b01; stop_bits = 1'b0; data_length = 1'b1;
    send_frame(8'h00, 8, 1, 1'b0, 1, 1'b1, BIT_2400);
    repeat (10) @(negedge clock);
    chk("ferr_done_cnt", done_cnt, 4);
    chk("ferr_data", data_out, 8'h00);
    chk("ferr_frame_error", frame_error, 1'b1);
    chk("ferr_parity_error", parity_error, 1'b0);

    // False start: low for 4 ticks at 9600
    baud_rate = 2'b10; parity_type = 2'b00;
    repeat (20) @(negedge clock);
    data_in = 1'b0;
    repeat (10) @(negedge clock);
    chk("false_start_active", rx_active, 1'b1);
    repeat (4 * TICK_9600 - 10) @(negedge clock);
    data_in = 1'b1;
    repeat (BIT_9600) @(negedge clock);
    chk("false_start_idle", rx_active, 1'b0);
    chk("false_start_no_done", done_cnt, 4);
    chk("false_start_data_held", data_out, 8'h00);
    chk("false_start_ferr_held", frame_error, 1'b1);

    // Back-to-back 8N2 at 4800, then data_length change mid-frame
    baud_rate = 2'b01; parity_type = 2'b00; stop_bits = 1'b1; data_length = 1'b1;
    send_frame(8'h3C, 8, 0, 1'b0, 2, 1'b0, BIT_4800);
    chk("b2b_first_done_cnt", done_cnt, 5);
    chk("b2b_first_data", data_out, 8'h3C);
    send_frame(8'hC3, 8, 0, 1'b0, 2, 1'b0, BIT_4800);
    chk("b2b_second_done_cnt", done_cnt, 6);
    chk("b2b_second_data", data_out, 8'hC3);
    chk("b2b_frame_error", frame_error, 1'b0);
    repeat (20) @(negedge clock);
    fork
      send_frame(8'h96, 8, 0, 1'b0, 2, 1'b0, BIT_4800);
      begin
        repeat (2 * BIT_4800) @(negedge clock);
        data_length = 1'b0;
      end
    join
    repeat (10) @(negedge clock);
    chk("len_change_done_cnt", done_cnt, 7);
    chk("len_change_data", data_out, 8'h96);
    data_length = 1'b1;

    // Reset during data bit 4, then a clean frame
    baud_rate = 2'b10; stop_bits = 1'b0;
    repeat (20) @(negedge clock);
    fork
      send_frame(8'hFF, 8, 0, 1'b0, 1, 1'b0, BIT_9600);
      begin
        repeat (5 * BIT_9600 + BIT_9600 / 2) @(negedge clock);
        chk("pre_rst_active", rx_active, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_data_out", data_out, 8'h00);
        chk("mid_rst_rx_active", rx_active, 1'b0);
        chk("mid_rst_rx_done", rx_done, 1'b0);
        chk("mid_rst_parity_error", parity_error, 1'b0);
        chk("mid_rst_frame_error", frame_error, 1'b0);
        repeat (BIT_9600) @(negedge clock);
        rst = 1'b1;
      end
    join
    repeat (20) @(negedge clock);
    chk("aborted_no_done", done_cnt, 7);
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b0, BIT_9600);
    repeat (10) @(negedge clock);
    chk("post_rst_done_cnt", done_cnt, 8);
    chk("post_rst_data", data_out, 8'h5A);
    chk("post_rst_frame_error", frame_error, 1'b0);
    chk("post_rst_parity_error", parity_error, 1'b0);
    chk("done_pulse_width", max_run, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's UART. It is the counterpart of the existing transmitter and accepts the same frame configuration: 7/8 data bits LSB-first, none/odd/even parity, and 1 or 2 stop bits at one of four baud rates. It oversamples the line at 16x, recovers the byte, checks parity and stop bits, and presents the byte on a parallel port with a one-cycle done strobe.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, sample ticks per bit. Fixed at 16; no other value is supported.
- clock  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- baud_rate  in  2  baud select: 00=2400, 01=4800, 10=9600, 11=19200.
- parity_type  in  2  parity mode: 00=none, 01=odd, 10=even, 11=none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
- data_in  in  1  serial line; idles high.
- data_out  out  8  received byte; bit 7 is 0 in 7-bit mode.
- rx_done  out  1  one-cycle pulse when a frame completes.
- rx_active  out  1  high from start-bit detection until the frame ends.
- parity_error  out  1  parity mismatch in the last frame; always 0 when parity is off.
- frame_error  out  1  a stop bit was sampled low in the last frame.

## Operation
- **Synchronizer.** data_in passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value.
- **Tick generator.** A free-running counter produces a one-cycle tick every DIV clocks, with DIV = round(CLK_HZ / (baud × 16)). At 50 MHz: 00→1302, 01→651, 10→326, 11→163. The counter restarts at 0 on start detection, so tick phase aligns to the start edge.
- **Config latch.** baud_rate, parity_type, stop_bits and data_length are latched on start detection. Changes mid-frame have no effect until the next frame.
- **IDLE.** On a synchronized 1→0 transition, go to START. Set rx_active=1 and clear the tick counter and sample counter.
- **START.**
  - At the 8th tick (mid-bit), if the line is 0: clear the sample counter and go to DATA.
  - If the line is 1 (glitch or false start): return to IDLE, set rx_active=0, and do not assert rx_done.
- **DATA.**
  - Every 16 ticks, sample mid-bit and shift into the shift register LSB-first.
  - After 7 or 8 bits (from latched data_length), go to PARITY if parity is enabled, otherwise go to STOP.
  - In 7-bit mode, shift register bit 7 is forced to 0.
- **PARITY.**
  - Sample mid-bit.
  - Expected bit: even mode = XOR of the received data bits; odd mode = its inverse.
  - Only the 7 received bits count in 7-bit mode.
  - Record a mismatch internally.
- **STOP.**
  - Sample one or two stop bits mid-bit, 16 ticks apart.
  - Any 0 sample sets the internal frame-error flag; reception still completes.
  - After the last stop sample, go to DONE.
- **DONE (one cycle).**
  - Load data_out, parity_error and frame_error from the internal values.
  - Pulse rx_done=1 and set rx_active=0.
  - Return to IDLE.
  - A new start edge is detectable from the next cycle. This tolerates a following start bit that arrives half a bit early.
- **Output hold.** data_out, parity_error and frame_error hold their values until the next DONE. They are never updated on a false start.
- **Reset.** Reset asserted at any time, including mid-frame, forces IDLE immediately and discards the partial frame.

## Timing
- Reset values: data_out=8'h00, rx_done=0, rx_active=0, parity_error=0, frame_error=0, FSM=IDLE, synchronizer flops=1.
- Detection latency: rx_active rises 3 clocks after data_in falls (2 synchronizer flops plus the edge register).
- Completion: rx_done asserts 1 clock after the mid-bit tick of the last stop bit. That is about (1 + N + P + S − 0.5) bit periods after the start edge, plus 3 clocks, where N = data bits, P = parity bit (0/1), S = stop bits.
- rx_done is exactly 1 cycle wide. It coincides with rx_active falling and with the new values appearing on data_out and the error flags.
- Sample points fall at tick 8 of each 16-tick bit window.
- Allowed baud mismatch: ±3% over a 12-bit frame.

## Test plan
- **Basic 8N1.** 9600 baud, 8N1, send 0xA5 → rx_done pulses once; data_out=0xA5; parity_error=0; frame_error=0; rx_active low afterwards.
- **Parity both ways.** 7E2 at 19200, send 0x41 with a correct even parity bit → data_out=0x41, parity_error=0. Same frame with the parity bit flipped → data_out=0x41, parity_error=1.
- **Frame error.** 8O1 at 2400, send 0x00 with the stop bit driven low → rx_done pulses; data_out=0x00; frame_error=1; parity_error=0.
- **False start.** Drive data_in low for 4 tick periods, then high → rx_active pulses, then returns low; no rx_done; data_out keeps its previous value.
- **Back-to-back frames.** 4800 8N2, send 0x3C then 0xC3 with no idle gap → two rx_done pulses, with data_out=0x3C then 0xC3. Then change data_length mid-frame → the current frame still decodes with the old length.
- **Reset mid-frame.** Deassert rst during data bit 4 → all outputs go to their reset values immediately. After rst is released, a clean 0x5A frame is received correctly.
